bist_tpg_16bit: RTL

BIST_TPG_16BIT -- requirements
Module: bist_tpg_16bit

---
 rtl/bist_pkg.sv | 18 +
 rtl/lfsr_16bit.sv | 25 ++
 rtl/bist_tpg_16bit.sv | 75 +++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared BIST definitions: datapath width, default seed, LFSR taps and FSM encoding.
// Also used by the MISR and the BIST controller.
package bist_pkg;

  localparam int WIDTH = 16;
  localparam logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1;
  // Taps for x^16+x^14+x^13+x^11+1 (state bits 15,13,12,10)
  localparam logic [WIDTH-1:0] TAP_MASK = 16'hB400;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] q);
    return {q[WIDTH-2:0], ^(q & TAP_MASK)};
  endfunction

endpackage

// File: rtl/lfsr_16bit.sv
// 16-bit Fibonacci LFSR with synchronous reset, parallel load and step enable.
module lfsr_16bit
  import bist_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/bist_tpg_16bit.sv
// BIST test pattern generator: emits NUM_PATTERNS LFSR vectors per run,
// with stall, seed load and a run counter.
module bist_tpg_16bit #(
  parameter int unsigned NUM_PATTERNS = 256,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hold,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  output logic [15:0] pattern,
  output logic        pattern_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] count
);
  import bist_pkg::*;

  localparam logic [15:0] LAST_CNT = 16'(NUM_PATTERNS);

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic        step_en;
  logic        seed_ld;
  logic [15:0] seed_val;

  assign step_en  = (state == ST_RUN) && !hold;
  // Seeds are only accepted between runs; zero would lock the LFSR up.
  assign seed_ld  = seed_load && (state != ST_RUN);
  assign seed_val = (seed_in == 16'h0000) ? DEFAULT_SEED : seed_in;
  assign cnt_inc  = cnt + 16'd1;

  lfsr_16bit #(
    .RESET_VAL (DEFAULT_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_ld),
    .load_val (seed_val),
    .en       (step_en),
    .q        (pattern)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 16'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_RUN;
            cnt   <= 16'd0;
          end
        end
        ST_RUN: begin
          if (!hold) begin
            cnt <= cnt_inc;
            if (cnt_inc == LAST_CNT) state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pattern_valid = step_en;
  assign busy          = (state == ST_RUN);
  assign done          = (state == ST_DONE);
  assign count         = cnt;

endmodule
